// File: rtl/rominit_router_if.sv
// Bundle of the hps_io ioctl stream and the ROM-init target bus; CHKSUM is
// present only when ROMINIT_CHKSUM_EN is defined.
interface rominit_router_if #(
    parameter int NUM_REGIONS = 4,
    parameter int ADDR_W      = 17
);
    logic                   IOCTL_DOWNLOAD;
    logic [7:0]             IOCTL_INDEX;
    logic                   IOCTL_WR;
    logic [24:0]            IOCTL_ADDR;
    logic [7:0]             IOCTL_DOUT;
    logic                   IOCTL_WAIT;
    logic                   ROMINIT_ACTIVE;
    logic [NUM_REGIONS-1:0] ROMINIT_SEL;
    logic [ADDR_W-1:0]      ROMINIT_ADDR;
    logic [7:0]             ROMINIT_DATA;
    logic                   ROMINIT_VALID;
    logic                   ROMINIT_READY;
    logic [ADDR_W:0]        CART_SIZE;
    logic                   ROMINIT_DONE;
    logic                   ROMINIT_OVERFLOW;
`ifdef ROMINIT_CHKSUM_EN
    logic [15:0]            CHKSUM;

    modport slave (
        input  IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DOUT, ROMINIT_READY,
        output IOCTL_WAIT, ROMINIT_ACTIVE, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA,
               ROMINIT_VALID, CART_SIZE, ROMINIT_DONE, ROMINIT_OVERFLOW, CHKSUM
    );
    modport master (
        output IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DOUT, ROMINIT_READY,
        input  IOCTL_WAIT, ROMINIT_ACTIVE, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA,
               ROMINIT_VALID, CART_SIZE, ROMINIT_DONE, ROMINIT_OVERFLOW, CHKSUM
    );
`else
    modport slave (
        input  IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DOUT, ROMINIT_READY,
        output IOCTL_WAIT, ROMINIT_ACTIVE, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA,
               ROMINIT_VALID, CART_SIZE, ROMINIT_DONE, ROMINIT_OVERFLOW
    );
    modport master (
        output IOCTL_DOWNLOAD, IOCTL_INDEX, IOCTL_WR, IOCTL_ADDR, IOCTL_DOUT, ROMINIT_READY,
        input  IOCTL_WAIT, ROMINIT_ACTIVE, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA,
               ROMINIT_VALID, CART_SIZE, ROMINIT_DONE, ROMINIT_OVERFLOW
    );
`endif
endinterface

// File: rtl/rominit_router.sv
// Routes the hps_io ioctl byte stream into NUM_REGIONS ROM/RAM regions with per-byte
// backpressure and cart-size measurement. Define ROMINIT_CHKSUM_EN to add CHKSUM.
module rominit_router #(
    parameter int                            NUM_REGIONS = 4,
    parameter int                            ADDR_W      = 17,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = '0,
    parameter logic [7:0]                    SYS_INDEX   = 8'd0,
    parameter logic [7:0]                    CART_INDEX  = 8'd1
) (
    input  logic                 CLK_SYS,
    input  logic                 RST,
    rominit_router_if.slave      io
);
    typedef enum logic [1:0] {IDLE, ACTIVE, HOLD, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic                   cart_q, cart_d;
    logic                   active_q, active_d;
    logic                   valid_q, valid_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic [ADDR_W:0]        size_q, size_d;
    logic [ADDR_W:0]        cart_size_q, cart_size_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
`ifdef ROMINIT_CHKSUM_EN
    logic [15:0]            chk_q, chk_d;
`endif

    logic                   route_hit;
    logic [NUM_REGIONS-1:0] route_sel;
    logic [ADDR_W-1:0]      route_addr;
    logic [ADDR_W:0]        size_cand;
    logic [31:0]            ioctl_a, route_base, route_lim;

    // Regions are packed back to back; a zero-sized region has an empty window.
    always_comb begin
        ioctl_a    = {7'd0, io.IOCTL_ADDR};
        route_hit  = 1'b0;
        route_sel  = '0;
        route_addr = '0;
        route_base = '0;
        route_lim  = '0;
        if (cart_q) begin
            if (ioctl_a < (32'd1 << ADDR_W)) begin
                route_hit                = 1'b1;
                route_sel[NUM_REGIONS-1] = 1'b1;
                route_addr               = io.IOCTL_ADDR[ADDR_W-1:0];
            end
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                route_lim = route_base + 32'(REGION_SIZE[i*ADDR_W +: ADDR_W]);
                if (!route_hit && ioctl_a >= route_base && ioctl_a < route_lim) begin
                    route_hit    = 1'b1;
                    route_sel[i] = 1'b1;
                    route_addr   = ADDR_W'(ioctl_a - route_base);
                end
                route_base = route_lim;
            end
        end
        if (ioctl_a >= (32'd1 << ADDR_W)) size_cand = (ADDR_W+1)'(1) << ADDR_W;
        else                              size_cand = (ADDR_W+1)'(ioctl_a + 32'd1);
    end

    always_comb begin
        state_d     = state_q;
        cart_d      = cart_q;
        active_d    = active_q;
        valid_d     = valid_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        data_d      = data_q;
        size_d      = size_q;
        cart_size_d = cart_size_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
`ifdef ROMINIT_CHKSUM_EN
        chk_d = chk_q;
        if (valid_q && io.ROMINIT_READY) chk_d = chk_q + 16'(data_q);
`endif
        case (state_q)
            IDLE: begin
                if (io.IOCTL_DOWNLOAD &&
                    (io.IOCTL_INDEX == SYS_INDEX || io.IOCTL_INDEX == CART_INDEX)) begin
                    state_d  = ACTIVE;
                    active_d = 1'b1;
                    cart_d   = (io.IOCTL_INDEX == CART_INDEX);
                    ovf_d    = 1'b0;
                    if (io.IOCTL_INDEX == CART_INDEX) size_d = '0;
`ifdef ROMINIT_CHKSUM_EN
                    chk_d = '0;
`endif
                end
            end
            ACTIVE, HOLD: begin
                // A write arriving while a byte is still pending is dropped.
                if (valid_q) begin
                    if (io.ROMINIT_READY) begin
                        valid_d = 1'b0;
                        state_d = ACTIVE;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (io.IOCTL_WR) begin
                    if (route_hit) begin
                        valid_d = 1'b1;
                        sel_d   = route_sel;
                        addr_d  = route_addr;
                        data_d  = io.IOCTL_DOUT;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (cart_q && size_cand > size_q) size_d = size_cand;
                end
                if (!io.IOCTL_DOWNLOAD) state_d = FLUSH;
            end
            FLUSH: begin
                if (!valid_q || io.ROMINIT_READY) begin
                    valid_d  = 1'b0;
                    done_d   = 1'b1;
                    active_d = 1'b0;
                    state_d  = IDLE;
                    if (cart_q) cart_size_d = size_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SYS) begin
        if (RST) begin
            state_q     <= IDLE;
            cart_q      <= 1'b0;
            active_q    <= 1'b0;
            valid_q     <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            size_q      <= '0;
            cart_size_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef ROMINIT_CHKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cart_q      <= cart_d;
            active_q    <= active_d;
            valid_q     <= valid_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            size_q      <= size_d;
            cart_size_q <= cart_size_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
`ifdef ROMINIT_CHKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign io.IOCTL_WAIT       = valid_q;
    assign io.ROMINIT_VALID    = valid_q;
    assign io.ROMINIT_ACTIVE   = active_q;
    assign io.ROMINIT_SEL      = sel_q;
    assign io.ROMINIT_ADDR     = addr_q;
    assign io.ROMINIT_DATA     = data_q;
    assign io.CART_SIZE        = cart_size_q;
    assign io.ROMINIT_DONE     = done_q;
    assign io.ROMINIT_OVERFLOW = ovf_q;
`ifdef ROMINIT_CHKSUM_EN
    assign io.CHKSUM           = chk_q;
`endif
endmodule

// File: tb/tb_rominit_router.sv
// Scoreboard bench for rominit_router: stimulus pushes expected routed bytes, a
// monitor pops them as the target accepts; region routing modelled as offsets.
module tb_rominit_router;
    localparam int NR = 4;
    localparam int AW = 17;
    localparam logic [NR*AW-1:0] RSIZE = {17'd0, 17'h00200, 17'h01000, 17'h02000};
    localparam logic [7:0] SYS  = 8'd0;
    localparam logic [7:0] CART = 8'd1;
    localparam int unsigned CART_LIM = 32'h20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rominit_router_if #(.NUM_REGIONS(NR), .ADDR_W(AW)) io ();

    rominit_router #(
        .NUM_REGIONS(NR), .ADDR_W(AW), .REGION_SIZE(RSIZE),
        .SYS_INDEX(SYS), .CART_INDEX(CART)
    ) dut (
        .CLK_SYS(clk),
        .RST(rst),
        .io(io)
    );

    typedef struct packed {
        logic [NR-1:0] sel;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    int unsigned reg_size [NR] = '{32'h2000, 32'h1000, 32'h200, 32'h0};
    bit          m_cart = 1'b0;
    bit          m_ovf = 1'b0;
    int unsigned m_size = 0;
    int unsigned m_cart_size = 0;
    int          rdy_mode = 0;
`ifdef ROMINIT_CHKSUM_EN
    logic [15:0] m_chk = '0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference routing: walk the region list subtracting sizes.
    function automatic bit model_route(input bit cart, input int unsigned a,
                                       output logic [NR-1:0] s, output logic [AW-1:0] ra);
        int unsigned off;
        s  = '0;
        ra = '0;
        if (cart) begin
            if (a >= CART_LIM) return 1'b0;
            s[NR-1] = 1'b1;
            ra      = a[AW-1:0];
            return 1'b1;
        end
        off = a;
        for (int i = 0; i < NR; i++) begin
            if (off < reg_size[i]) begin
                s[i] = 1'b1;
                ra   = off[AW-1:0];
                return 1'b1;
            end
            off -= reg_size[i];
        end
        return 1'b0;
    endfunction

    // READY driver: 0 = always ready, 1 = random, 2 = driven by the stimulus.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0)      io.ROMINIT_READY = 1'b1;
            else if (rdy_mode == 1) io.ROMINIT_READY = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every accepted byte.
    initial begin
        bit   prev_hold;
        exp_t prev_out, cur, e;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                cur.sel  = io.ROMINIT_SEL;
                cur.addr = io.ROMINIT_ADDR;
                cur.data = io.ROMINIT_DATA;
                if (io.ROMINIT_VALID || io.IOCTL_WAIT)
                    check("wait_tracks_valid", 32'(io.IOCTL_WAIT), 32'(io.ROMINIT_VALID));
                if (io.ROMINIT_VALID) begin
                    if (prev_hold) check("hold_stable", 32'(cur), 32'(prev_out));
                    if (io.ROMINIT_READY) begin
                        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("byte_sel", 32'(cur.sel), 32'(e.sel));
                            check("byte_addr", 32'(cur.addr), 32'(e.addr));
                            check("byte_data", 32'(cur.data), 32'(e.data));
`ifdef ROMINIT_CHKSUM_EN
                            m_chk = m_chk + 16'(e.data);
`endif
                        end
                    end
                end
                prev_hold = io.ROMINIT_VALID && !io.ROMINIT_READY;
                prev_out  = cur;
                if (io.ROMINIT_DONE) done_cnt++;
            end
        end
    end

    task automatic model_start(input logic [7:0] idx);
        m_cart = (idx == CART);
        m_ovf  = 1'b0;
        if (m_cart) m_size = 0;
`ifdef ROMINIT_CHKSUM_EN
        m_chk = '0;
`endif
    endtask

    task automatic start_dl(input logic [7:0] idx);
        io.IOCTL_INDEX    = idx;
        io.IOCTL_DOWNLOAD = 1'b1;
        model_start(idx);
        @(posedge clk);
        #1;
        check("active_rise", 32'(io.ROMINIT_ACTIVE), 32'd1);
        check("ovf_clear_on_start", 32'(io.ROMINIT_OVERFLOW), 32'd0);
    endtask

    // Records the expected outcome of one byte write issued this cycle.
    task automatic expect_byte(input int unsigned a, input logic [7:0] d);
        logic [NR-1:0] s;
        logic [AW-1:0] ra;
        exp_t          e;
        if (model_route(m_cart, a, s, ra)) begin
            e.sel  = s;
            e.addr = ra;
            e.data = d;
            exp_q.push_back(e);
        end else begin
            m_ovf = 1'b1;
        end
        if (m_cart) begin
            if (a >= CART_LIM) begin
                if (CART_LIM > m_size) m_size = CART_LIM;
            end else if (a + 1 > m_size) begin
                m_size = a + 1;
            end
        end
    endtask

    task automatic send(input int unsigned a, input logic [7:0] d, input bit last, output int wc);
        io.IOCTL_WR   = 1'b1;
        io.IOCTL_ADDR = a[24:0];
        io.IOCTL_DOUT = d;
        if (last) io.IOCTL_DOWNLOAD = 1'b0;
        expect_byte(a, d);
        @(posedge clk);
        #1;
        io.IOCTL_WR = 1'b0;
        wc = 0;
        while (io.IOCTL_WAIT && wc < 100) begin
            wc++;
            @(posedge clk);
            #1;
        end
        if (wc >= 100) check("wait_timeout", 32'(wc), 32'd0);
    endtask

    task automatic wait_done(input bit rerise, input logic [7:0] idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!io.ROMINIT_DONE && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("done_seen", 32'(io.ROMINIT_DONE), 32'd1);
        done_exp++;
        if (m_cart) m_cart_size = m_size;
        check("done_active_low", 32'(io.ROMINIT_ACTIVE), 32'd0);
        check("cart_size", 32'(io.CART_SIZE), m_cart_size);
        check("overflow", 32'(io.ROMINIT_OVERFLOW), 32'(m_ovf));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef ROMINIT_CHKSUM_EN
        check("chksum", 32'(io.CHKSUM), 32'(m_chk));
`endif
        if (rerise) begin
            io.IOCTL_INDEX    = idx;
            io.IOCTL_DOWNLOAD = 1'b1;
            model_start(idx);
        end
        @(negedge clk);
        check("done_single_pulse", 32'(io.ROMINIT_DONE), 32'd0);
        if (rerise) check("rerise_active", 32'(io.ROMINIT_ACTIVE), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_active"}, 32'(io.ROMINIT_ACTIVE), 32'd0);
        check({tag, "_valid"}, 32'(io.ROMINIT_VALID), 32'd0);
        check({tag, "_wait"}, 32'(io.IOCTL_WAIT), 32'd0);
        check({tag, "_sel"}, 32'(io.ROMINIT_SEL), 32'd0);
        check({tag, "_addr"}, 32'(io.ROMINIT_ADDR), 32'd0);
        check({tag, "_data"}, 32'(io.ROMINIT_DATA), 32'd0);
        check({tag, "_cart_size"}, 32'(io.CART_SIZE), 32'd0);
        check({tag, "_done"}, 32'(io.ROMINIT_DONE), 32'd0);
        check({tag, "_overflow"}, 32'(io.ROMINIT_OVERFLOW), 32'd0);
    endtask

    initial begin
        int          wc;
        int unsigned a;
        logic [7:0]  d7;
        logic [7:0]  cb [4];
        cb = '{8'hFF, 8'hFF, 8'h01, 8'h02};
        io.IOCTL_DOWNLOAD = 1'b0;
        io.IOCTL_INDEX    = 8'd0;
        io.IOCTL_WR       = 1'b0;
        io.IOCTL_ADDR     = '0;
        io.IOCTL_DOUT     = '0;
        io.ROMINIT_READY  = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full system image, always ready: one wait cycle per byte.
        start_dl(SYS);
        for (int i = 0; i < 'h3200; i++) begin
            send(i, 8'($urandom), 1'b0, wc);
            check("sys_wait_one_cycle", 32'(wc), 32'd1);
        end
        io.IOCTL_DOWNLOAD = 1'b0;
        wait_done(1'b0, SYS);

        // System image with bytes beyond the last region.
        start_dl(SYS);
        for (int i = 0; i < 64; i++) send($urandom_range(0, 'h31FF), 8'($urandom), 1'b0, wc);
        send('h3200, 8'hA5, 1'b0, wc);
        check("oob_no_wait", 32'(wc), 32'd0);
        check("oob_overflow_set", 32'(io.ROMINIT_OVERFLOW), 32'd1);
        send('h1FFFFFF, 8'h5A, 1'b0, wc);
        check("oob_top_no_wait", 32'(wc), 32'd0);
        send('h31FF, 8'h3C, 1'b0, wc);
        io.IOCTL_DOWNLOAD = 1'b0;
        wait_done(1'b0, SYS);

        // 32 KiB cart with random READY; sparse above 4 KiB, ends at 0x7FFF.
        rdy_mode = 1;
        start_dl(CART);
        for (int i = 0; i < 'h1000; i++) send(i, 8'($urandom), 1'b0, wc);
        a = 'h1000;
        while (a < 'h7FFF) begin
            send(a, 8'($urandom), 1'b0, wc);
            a += $urandom_range(1, 64);
        end
        send('h7FFF, 8'($urandom), 1'b0, wc);
        io.IOCTL_DOWNLOAD = 1'b0;
        wait_done(1'b0, CART);
        rdy_mode = 0;

        // Second cart of 8 KiB; final write coincides with the download fall.
        start_dl(CART);
        for (int i = 0; i < 'h2000; i++) send(i, 8'($urandom), (i == 'h1FFF), wc);
        wait_done(1'b1, SYS);

        // System download restarted in the DONE cycle; READY low 5 cycles on byte 7.
        for (int i = 0; i < 7; i++) send(i, 8'($urandom), 1'b0, wc);
        rdy_mode = 2;
        io.ROMINIT_READY = 1'b0;
        d7 = 8'($urandom);
        io.IOCTL_WR   = 1'b1;
        io.IOCTL_ADDR = 25'd7;
        io.IOCTL_DOUT = d7;
        expect_byte(7, d7);
        @(posedge clk);
        #1;
        io.IOCTL_WR = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", 32'(io.ROMINIT_VALID), 32'd1);
            check("stall_wait", 32'(io.IOCTL_WAIT), 32'd1);
            io.IOCTL_WR = (k == 2);
            if (k == 2) begin
                io.IOCTL_ADDR = 25'd100;
                io.IOCTL_DOUT = ~d7;
            end
            @(posedge clk);
            #1;
        end
        io.IOCTL_WR = 1'b0;
        io.ROMINIT_READY = 1'b1;
        check("stall_release_valid", 32'(io.ROMINIT_VALID), 32'd1);
        @(posedge clk);
        #1;
        check("stall_accepted", 32'(io.ROMINIT_VALID), 32'd0);
        rdy_mode = 0;
        for (int i = 8; i < 16; i++) send(i, 8'($urandom), 1'b0, wc);
        io.IOCTL_DOWNLOAD = 1'b0;
        wait_done(1'b0, SYS);

        // Unknown index is ignored.
        io.IOCTL_INDEX    = 8'd5;
        io.IOCTL_DOWNLOAD = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("bad_index_idle", 32'(io.ROMINIT_ACTIVE), 32'd0);
        io.IOCTL_WR   = 1'b1;
        io.IOCTL_ADDR = 25'd0;
        @(posedge clk);
        #1;
        io.IOCTL_WR = 1'b0;
        check("bad_index_no_valid", 32'(io.ROMINIT_VALID), 32'd0);
        io.IOCTL_DOWNLOAD = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a cart download with a byte pending.
        start_dl(CART);
        for (int i = 0; i < 3; i++) send(i, 8'($urandom), 1'b0, wc);
        rdy_mode = 2;
        io.ROMINIT_READY = 1'b0;
        io.IOCTL_WR   = 1'b1;
        io.IOCTL_ADDR = 25'd3;
        io.IOCTL_DOUT = 8'h77;
        @(posedge clk);
        #1;
        io.IOCTL_WR = 1'b0;
        check("pending_before_rst", 32'(io.ROMINIT_VALID), 32'd1);
        rst = 1'b1;
        io.IOCTL_DOWNLOAD = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b0;
        exp_q.delete();
        m_cart_size = 0;
        m_ovf = 1'b0;
        rdy_mode = 0;
        io.ROMINIT_READY = 1'b1;
        @(posedge clk);
        #1;

        // Clean restart: four-byte cart FF,FF,01,02.
        start_dl(CART);
        for (int i = 0; i < 4; i++) send(i, cb[i], 1'b0, wc);
        io.IOCTL_DOWNLOAD = 1'b0;
        wait_done(1'b0, CART);
        check("small_cart_size", 32'(io.CART_SIZE), 32'h4);
`ifdef ROMINIT_CHKSUM_EN
        check("chksum_ff_ff_01_02", 32'(io.CHKSUM), 32'h0201);
`endif

        // Cart addresses at and beyond the address range: size saturates.
        start_dl(CART);
        send('h1FFFF, 8'h11, 1'b0, wc);
        send('h20005, 8'h22, 1'b0, wc);
        check("cart_oob_no_wait", 32'(wc), 32'd0);
        io.IOCTL_DOWNLOAD = 1'b0;
        wait_done(1'b0, CART);

        check("done_count", 32'(done_cnt), 32'(done_exp));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule
